// File: rtl/wr_beat_packer_pkg.sv
// Shared write/read-side FIFO definitions: default geometry and small helpers.
package wr_beat_packer_pkg;

  localparam int DW_DEF    = 8;
  localparam int RATIO_DEF = 4;

  // Ceiling log2, at least 1 so that derived vectors never collapse to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

  // Bit offset of beat slot k inside a packed word.
  function automatic int slot_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/wr_beat_packer_word_queue2.sv
// Two-entry FIFO holding completed {wlast, wcnt, wdata} words; head reads as zero when empty.
module wr_word_queue2 #(
  parameter int EW = 36
) (
  input  logic          clk,
  input  logic          wreset,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head_data,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [EW-1:0] entry0;
  logic [EW-1:0] entry1;
  logic          do_pop;

  assign do_pop     = pop & (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_data  = head_valid ? entry0 : '0;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk or posedge wreset) begin
    if (wreset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (push && do_pop) begin
      if (count == 2'd1) begin
        entry0 <= push_data;
      end else begin
        entry0 <= entry1;
        entry1 <= push_data;
      end
    end else if (push) begin
      if (count == 2'd0) entry0 <= push_data;
      else               entry1 <= push_data;
      count <= count + 2'd1;
    end else if (do_pop) begin
      entry0 <= entry1;
      entry1 <= '0;
      count  <= count - 2'd1;
    end
  end

endmodule

// File: rtl/wr_beat_packer.sv
// Packs RATIO narrow beats into one FIFO word and feeds the write pointer handler.
module wr_beat_packer
  import wr_beat_packer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RATIO = RATIO_DEF,
  parameter int CW    = clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                wreset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  input  logic                s_last,
  input  logic                full,
  output logic                winc,
  output logic [DW*RATIO-1:0] wdata,
  output logic [CW-1:0]       wcnt,
  output logic                wlast
);

  localparam int WW = DW * RATIO;
  localparam int IW = clog2(RATIO);
  localparam int EW = 1 + CW + WW;

  logic [IW-1:0] idx;
  logic [WW-1:0] pack_q;
  logic [WW-1:0] word_now;
  logic [CW-1:0] push_cnt;
  logic          accept;
  logic          last_slot;
  logic          complete;
  logic [1:0]    q_count;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic          head_valid;

  // s_ready looks only at the registered queue depth, so full never reaches it combinationally.
  assign s_ready   = ~wreset & (q_count != 2'd2);
  assign accept    = s_valid & s_ready;
  assign last_slot = (idx == IW'(RATIO - 1));
  assign complete  = accept & (last_slot | s_last);
  assign push_cnt  = CW'(idx) + CW'(1);

  // Current pack register with the incoming beat merged into its slot.
  always_comb begin
    word_now = pack_q;
    word_now[slot_lsb(int'(idx), DW) +: DW] = s_data;
  end

  assign push_entry = {s_last, push_cnt, word_now};

  // Slot index and pack register; a completed word leaves both cleared for the next packet.
  always_ff @(posedge clk or posedge wreset) begin
    if (wreset) begin
      idx    <= '0;
      pack_q <= '0;
    end else if (complete) begin
      idx    <= '0;
      pack_q <= '0;
    end else if (accept) begin
      idx    <= idx + IW'(1);
      pack_q <= word_now;
    end
  end

  wr_word_queue2 #(.EW(EW)) u_queue (
    .clk        (clk),
    .wreset     (wreset),
    .push       (complete),
    .push_data  (push_entry),
    .pop        (winc),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .count      (q_count)
  );

  assign winc = head_valid & ~full;
  assign {wlast, wcnt, wdata} = head_entry;

endmodule
